// File: rtl/mips_ctrl_pkg.sv
// Shared control-bundle definitions for the MIPS decoder and the control pipeline.
// Bundle layouts, bit positions, bubble constants and stage-register payloads.
package mips_ctrl_pkg;

    localparam int unsigned REG_W = 5;
    localparam int unsigned EX_W  = 4;
    localparam int unsigned MEM_W = 3;
    localparam int unsigned WB_W  = 2;

    // EX bundle bit positions
    localparam int unsigned ALU_SRC  = 3;
    localparam int unsigned ALUOP_HI = 2;
    localparam int unsigned ALUOP_LO = 1;
    localparam int unsigned REG_DST  = 0;

    // MEM bundle bit positions
    localparam int unsigned MEM_WRITE = 2;
    localparam int unsigned MEM_READ  = 1;
    localparam int unsigned BRANCH    = 0;

    // WB bundle bit positions
    localparam int unsigned WB_ALU    = 1;
    localparam int unsigned REG_WRITE = 0;

    typedef logic [EX_W-1:0]  ex_ctrl_t;
    typedef logic [MEM_W-1:0] mem_ctrl_t;
    typedef logic [WB_W-1:0]  wb_ctrl_t;
    typedef logic [REG_W-1:0] reg_idx_t;

    localparam ex_ctrl_t  EX_NOP  = EX_W'(0);
    localparam mem_ctrl_t MEM_NOP = MEM_W'(0);
    localparam wb_ctrl_t  WB_NOP  = WB_W'(0);
    localparam reg_idx_t  REG_ZERO = REG_W'(0);

    typedef struct packed {
        ex_ctrl_t  ex;
        mem_ctrl_t mem;
        wb_ctrl_t  wb;
        reg_idx_t  rt;
        reg_idx_t  rd;
    } id_ex_t;

    typedef struct packed {
        mem_ctrl_t mem;
        wb_ctrl_t  wb;
        reg_idx_t  dst;
    } ex_mem_t;

    typedef struct packed {
        wb_ctrl_t  wb;
        reg_idx_t  dst;
    } mem_wb_t;

    localparam id_ex_t  ID_EX_NOP  = '{ex: EX_NOP, mem: MEM_NOP, wb: WB_NOP, rt: REG_ZERO, rd: REG_ZERO};
    localparam ex_mem_t EX_MEM_NOP = '{mem: MEM_NOP, wb: WB_NOP, dst: REG_ZERO};
    localparam mem_wb_t MEM_WB_NOP = '{wb: WB_NOP, dst: REG_ZERO};

    // Write register selected by RegDst: rd for R-type, rt otherwise.
    function automatic reg_idx_t resolve_dst(ex_ctrl_t ex, reg_idx_t rt, reg_idx_t rd);
        return ex[REG_DST] ? rd : rt;
    endfunction

endpackage

// File: rtl/ctrl_pipe_if.sv
// Decode-side inputs and per-stage control outputs of the control pipeline.
interface ctrl_pipe_if;
    import mips_ctrl_pkg::*;

    logic [EX_W-1:0]  id_ex;
    logic [MEM_W-1:0] id_mem;
    logic [WB_W-1:0]  id_wb;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic [REG_W-1:0] id_rd;
    logic             mem_zero;

    logic [EX_W-1:0]  ex_ctrl;
    logic [MEM_W-1:0] mem_ctrl;
    logic [WB_W-1:0]  wb_ctrl;
    logic [REG_W-1:0] ex_rt;
    logic [REG_W-1:0] mem_dst;
    logic [REG_W-1:0] wb_dst;
    logic             stall;
    logic             flush;

    modport master (
        output id_ex, id_mem, id_wb, id_rs, id_rt, id_rd, mem_zero,
        input  ex_ctrl, mem_ctrl, wb_ctrl, ex_rt, mem_dst, wb_dst, stall, flush
    );

    modport slave (
        input  id_ex, id_mem, id_wb, id_rs, id_rt, id_rd, mem_zero,
        output ex_ctrl, mem_ctrl, wb_ctrl, ex_rt, mem_dst, wb_dst, stall, flush
    );

endinterface

// File: rtl/ctrl_pipe_hazard_detect.sv
// Load-use stall and taken-branch flush detection; a flush always suppresses the stall
// because the stalled instruction is being squashed anyway.
module hazard_detect
    import mips_ctrl_pkg::*;
(
    input  logic     mem_read,
    input  reg_idx_t ex_rt,
    input  reg_idx_t id_rs,
    input  reg_idx_t id_rt,
    input  logic     branch,
    input  logic     mem_zero,
    output logic     stall,
    output logic     flush
);

    logic load_use;

    always_comb begin
        flush    = branch && mem_zero;
        load_use = mem_read && (ex_rt != REG_ZERO) && ((ex_rt == id_rs) || (ex_rt == id_rt));
        stall    = load_use && !flush;
    end

endmodule

// File: rtl/ctrl_pipe.sv
// Carries decoded control bundles through ID/EX, EX/MEM and MEM/WB and inserts
// bubbles for load-use stalls and taken-branch flushes.
module ctrl_pipe
    import mips_ctrl_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    ctrl_pipe_if.slave   bus
);

    id_ex_t  id_ex_q;
    ex_mem_t ex_mem_q;
    mem_wb_t mem_wb_q;

    logic stall;
    logic flush;

    hazard_detect u_hazard (
        .mem_read (id_ex_q.mem[MEM_READ]),
        .ex_rt    (id_ex_q.rt),
        .id_rs    (bus.id_rs),
        .id_rt    (bus.id_rt),
        .branch   (ex_mem_q.mem[BRANCH]),
        .mem_zero (bus.mem_zero),
        .stall    (stall),
        .flush    (flush)
    );

    // ID/EX: bubble on stall or flush, otherwise capture the decoded bundles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_ex_q <= ID_EX_NOP;
        end else if (stall || flush) begin
            id_ex_q <= ID_EX_NOP;
        end else begin
            id_ex_q <= '{ex: bus.id_ex, mem: bus.id_mem, wb: bus.id_wb,
                         rt: bus.id_rt, rd: bus.id_rd};
        end
    end

    // EX/MEM: squashed on flush; the write register is resolved here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_mem_q <= EX_MEM_NOP;
        end else if (flush) begin
            ex_mem_q <= EX_MEM_NOP;
        end else begin
            ex_mem_q <= '{mem: id_ex_q.mem, wb: id_ex_q.wb,
                          dst: resolve_dst(id_ex_q.ex, id_ex_q.rt, id_ex_q.rd)};
        end
    end

    // MEM/WB always advances so a taken branch still retires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_wb_q <= MEM_WB_NOP;
        end else begin
            mem_wb_q <= '{wb: ex_mem_q.wb, dst: ex_mem_q.dst};
        end
    end

    assign bus.ex_ctrl  = id_ex_q.ex;
    assign bus.ex_rt    = id_ex_q.rt;
    assign bus.mem_ctrl = ex_mem_q.mem;
    assign bus.mem_dst  = ex_mem_q.dst;
    assign bus.wb_ctrl  = mem_wb_q.wb;
    assign bus.wb_dst   = mem_wb_q.dst;
    assign bus.stall    = stall;
    assign bus.flush    = flush;

endmodule
